fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Drain stage downstream of the 8-bit synchronous FIFO. Watches the FIFO's wrptr/rdptr,
//  issues one-cycle rd pops when data is present, captures dout and serialises each byte
//  onto a UART-style line (start, 8 data LSB-first, optional even parity, stop).
//  Sits between the FIFO read port and the chip-level txd pin.
// PARAMETERS
//  DATA_W        8    byte width; must match FIFO din/dout
//  PTR_W         4    FIFO pointer width; MSB is the wrap bit, depth = 2**(PTR_W-1)
//  CLKS_PER_BIT  16   clk cycles per serial bit; must be >= 2
//  PARITY_EN     0    1 = insert even-parity bit between data and stop
//  RD_LAT        1    cycles from rd asserted to valid dout; legal values 1..3
// PORTS
//  clk      in   1       system clock, all logic on posedge
//  rst      in   1       asynchronous, active-low reset
//  en       in   1       1 = allowed to start new frames
//  wrptr    in   PTR_W   FIFO write pointer
//  rdptr    in   PTR_W   FIFO read pointer
//  dout     in   DATA_W  FIFO read data
//  rd       out  1       FIFO pop strobe, single-cycle pulse
//  txd      out  1       serial line, idles high
//  busy     out  1       1 from pop until end of stop bit
//  done     out  1       1-cycle pulse on last cycle of stop bit
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rd=0, txd=1, busy=0, done=0, counters=0,
//   shift reg=0. Release takes effect on first posedge with rst=1.
//  avail = (wrptr != rdptr), full 4-bit compare incl. wrap bit (wrptr==rdptr -> empty).
//  FSM: IDLE -> POP -> WAIT -> START -> DATA -> [PAR] -> STOP -> IDLE.
//   IDLE : txd=1. If en && avail: rd=1 for exactly this cycle, busy=1, go POP.
//   POP  : rd=0; latency counter loads RD_LAT-1; go WAIT.
//   WAIT : when counter==0 capture dout into shift reg, go START; else decrement.
//   START: txd=0 for CLKS_PER_BIT cycles.
//   DATA : txd=shift[0], shift right every CLKS_PER_BIT; bit counter 0..DATA_W-1.
//   PAR  : only if PARITY_EN; txd=^captured byte (even parity), CLKS_PER_BIT cycles.
//   STOP : txd=1 for CLKS_PER_BIT cycles; done=1 on final cycle; busy drops next cycle.
//  Back-to-back: IDLE re-evaluates avail on the cycle after STOP; min gap between
//   frames = 1 idle cycle + RD_LAT + 1 cycles (txd held 1 throughout).
//  One pop per frame only; pointers sampled in IDLE only, so a pop is never issued
//   before the previous pop's rdptr update is visible (update occurs >= 1 frame earlier).
//  en deasserted mid-frame: current frame completes normally; no further pops.
//  Pointer wrap (e.g. wrptr 4'b1000, rdptr 4'b0111): treated as not-empty; no special case.
//  Baud counter width = $clog2(CLKS_PER_BIT); bit counter width = $clog2(DATA_W+1).
//  Simultaneous FIFO write during IDLE pop: no effect; next frame sees new wrptr.
//  Reset mid-frame: txd returns to 1 immediately, captured byte discarded (already popped).
// STRUCTURE
//  Shared package: FSM state encoding (IDLE,POP,WAIT,START,DATA,PAR,STOP), line-idle
//   level constant, default DATA_W/PTR_W shared with the FIFO.
//  One sub-module: uart_baud_tick (counter, tick on CLKS_PER_BIT-1, sync clear on
//   frame start); FSM, latency counter and shifter stay in fifo_uart_tx.
// TESTING (CLKS_PER_BIT=4, RD_LAT=1, PARITY_EN=0 unless stated; real fifo as source)
//  1 Reset: rst=0 mid-DATA -> txd=1, rd=0, busy=0 same cycle; no frame after release
//    while FIFO empty.
//  2 Single byte 8'hA5 written, en=1 -> exactly one rd pulse; txd = 0,1,0,1,0,0,1,0,1,1
//    each held 4 clks; done pulses once; total 40 clks start-to-stop.
//  3 Three bytes 8'h01,8'h80,8'hFF queued -> three frames in order, 3 rd pulses, idle
//    gap between frames = 3 clks, FIFO empty afterwards (wrptr==rdptr).
//  4 en=0 with 2 bytes queued -> no rd, txd=1; raise en -> both frames sent; drop en
//    during frame 1 -> frame 1 completes, frame 2 withheld.
//  5 PARITY_EN=1, byte 8'h07 -> parity bit 1 after data; byte 8'h03 -> parity 0;
//    frame length 44 clks.
//  6 Wrap: push/pop 20 bytes through depth-8 FIFO with random write gaps -> all 20
//    received serially in order, no extra or missing rd pulses across pointer wrap.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: FSM encoding, line level and default widths shared by the
// FIFO drain / UART transmit slice.
`default_nettype none

package fifo_uart_tx_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PTR_W  = 4;

  localparam logic LINE_IDLE = 1'b1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_PAR   = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;

  // True while a bit is being driven onto the line (baud counter runs).
  function automatic logic in_frame(input logic [2:0] s);
    return (s == S_START) || (s == S_DATA) || (s == S_PAR) || (s == S_STOP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_baud.sv
// uart_baud_tick: bit-period counter; ticks on its last count, held cleared
// outside a frame so every frame starts on a full bit period.
`default_nettype none

module uart_baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one byte at a time from a synchronous FIFO and shifts it
// out as a UART frame (start, data LSB-first, optional even parity, stop).
`default_nettype none

module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int PTR_W        = DEF_PTR_W,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int RD_LAT       = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [PTR_W-1:0]  wrptr_i,
  input  logic [PTR_W-1:0]  rdptr_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              rd_o,
  output logic              txd_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int LW = $clog2(RD_LAT + 1);

  logic [2:0]        state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tick;
  logic              avail;
  logic              pop;

  // Full compare including the wrap bit: equal pointers mean empty.
  assign avail  = (wrptr_i != rdptr_i);
  assign pop    = rst_ni && en_i && avail && (state_q == S_IDLE);
  assign rd_o   = pop;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_STOP) && tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (!in_frame(state_q)),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_POP;
      S_POP: begin
        lat_d   = LW'(RD_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          shift_d = dout_i;
          par_d   = ^dout_i;
          state_d = S_START;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_W - 1)) state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
          else                          bit_d   = bit_q + BW'(1);
        end
      end
      S_PAR:   if (tick) state_d = S_STOP;
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded straight from state so an asynchronous reset idles the line at once.
  always_comb begin
    case (state_q)
      S_START: txd_o = ~LINE_IDLE;
      S_DATA:  txd_o = shift_q[0];
      S_PAR:   txd_o = par_q;
      default: txd_o = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two transmitters (parity off / on) fed by depth-8 FIFOs,
// checked every cycle against a frame-timeline model of the serial line.
`default_nettype none

module tb_fifo_uart_tx;

  localparam int CPB    = 4;
  localparam int RD_LAT = 1;
  localparam int NCH    = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       push  = 1'b0;
  logic [7:0] pbyte = 8'h00;

  logic [3:0] wrptr [NCH] = '{default: '0};
  logic [3:0] rdptr [NCH] = '{default: '0};
  logic [7:0] dout  [NCH] = '{default: '0};
  logic [7:0] mem   [NCH][8];

  logic rd_w [NCH];
  logic txd_w [NCH];
  logic busy_w [NCH];
  logic done_w [NCH];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  pushed [$];
  int          ridx  [NCH] = '{default: 0};
  int          k     [NCH] = '{default: -1};
  logic [7:0]  cur   [NCH] = '{default: '0};
  int          rdc   [NCH] = '{default: 0};
  int          dnc   [NCH] = '{default: 0};
  int          flen  [NCH] = '{default: 0};
  int          gap   [NCH] = '{default: 0};
  int          st    [NCH] = '{default: 0};
  int          ldone [NCH] = '{default: 0};
  logic        infr  [NCH] = '{default: 1'b0};
  logic [10:0] fbits [NCH] = '{default: '0};

  always #5 clk = ~clk;

  for (genvar d = 0; d < NCH; d++) begin : g_dut
    fifo_uart_tx #(
      .DATA_W      (8),
      .PTR_W       (4),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (d),
      .RD_LAT      (RD_LAT)
    ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (en),
      .wrptr_i(wrptr[d]),
      .rdptr_i(rdptr[d]),
      .dout_i (dout[d]),
      .rd_o   (rd_w[d]),
      .txd_o  (txd_w[d]),
      .busy_o (busy_w[d]),
      .done_o (done_w[d])
    );
  end

  // Source FIFOs: registered read data, one cycle after rd.
  always @(posedge clk) begin
    for (int d = 0; d < NCH; d++) begin
      if (rd_w[d]) begin
        dout[d]  <= mem[d][rdptr[d][2:0]];
        rdptr[d] <= rdptr[d] + 4'd1;
      end
      if (push) begin
        mem[d][wrptr[d][2:0]] <= pbyte;
        wrptr[d]              <= wrptr[d] + 4'd1;
      end
    end
  end

  function automatic logic frame_bit(input logic [7:0] b, input int i, input int nb);
    if (i == 0)      return 1'b0;
    if (i <= 8)      return b[i-1];
    if (i == nb - 1) return 1'b1;
    return ^b;
  endfunction

  function automatic logic [3:0] fcount(input int d);
    return 4'(wrptr[d] - rdptr[d]);
  endfunction

  // Model: a pop starts a timeline; bit i of the frame occupies
  // cycles pre+i*CPB .. pre+(i+1)*CPB-1 after the pop cycle.
  initial begin
    int nb, b, pre, off;
    logic [3:0] want;
    logic tx, dn;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < NCH; d++) begin
        nb  = (d == 1) ? 11 : 10;
        pre = 2 + RD_LAT;
        if (!rst_n) begin
          want = 4'b0100;
          k[d] = -1;
        end else if (k[d] < 0) begin
          want = {en && (ridx[d] < pushed.size()), 1'b1, 1'b0, 1'b0};
          if (want[3]) begin
            cur[d] = pushed[ridx[d]];
            ridx[d]++;
            k[d] = 1;
          end
        end else begin
          b    = k[d] - pre;
          tx   = (b < 0) ? 1'b1 : frame_bit(cur[d], b / CPB, nb);
          dn   = (b == nb * CPB - 1);
          want = {1'b0, tx, 1'b1, dn};
          k[d] = dn ? -1 : k[d] + 1;
        end
        checks++;
        if ({rd_w[d], txd_w[d], busy_w[d], done_w[d]} !== want) begin
          errors++;
          $display("FAIL line_ch%0d cycle %0d {rd,txd,busy,done}: got %b expected %b",
                   d, cyc, {rd_w[d], txd_w[d], busy_w[d], done_w[d]}, want);
        end
        // Measurements taken from the DUT pins for the literal checks.
        if (!rst_n) begin
          infr[d] = 1'b0;
        end else begin
          if (rd_w[d])   rdc[d]++;
          if (done_w[d]) dnc[d]++;
          if (!infr[d] && !txd_w[d]) begin
            infr[d]  = 1'b1;
            st[d]    = cyc;
            gap[d]   = cyc - ldone[d] - 1;
            fbits[d] = '0;
          end
          if (infr[d]) begin
            off = cyc - st[d];
            if ((off % CPB) == 2 && (off / CPB) < 11) fbits[d][off / CPB] = txd_w[d];
          end
          if (done_w[d] && infr[d]) begin
            infr[d]  = 1'b0;
            flen[d]  = cyc - st[d] + 1;
            ldone[d] = cyc;
          end
        end
      end
      if (push) pushed.push_back(pbyte);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int w;
    w = 0;
    while (fcount(0) >= 4'd8 || fcount(1) >= 4'd8) begin
      tick(1);
      w++;
      if (w > 2000) begin
        checks++;
        errors++;
        $display("FAIL push_space: got full after %0d cycles expected space", w);
        return;
      end
    end
    pbyte = b;
    push  = 1'b1;
    tick(1);
    push  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input logic need_empty);
    int n;
    n = 0;
    while (busy_w[0] || busy_w[1] || (need_empty && (fcount(0) != 0 || fcount(1) != 0))) begin
      tick(1);
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
        return;
      end
    end
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int b0, b1;
    tick(3);
    chk("reset_txd", txd_w[0], 1);
    chk("reset_rd", rd_w[0], 0);
    chk("reset_busy", busy_w[1], 0);
    rst_n = 1'b1;
    tick(5);

    // Single byte A5
    en = 1'b1;
    b0 = rdc[0]; b1 = dnc[0];
    push_byte(8'hA5);
    wait_idle("t2", 1'b1);
    chk("t2_rd_pulses", rdc[0] - b0, 1);
    chk("t2_done_pulses", dnc[0] - b1, 1);
    chk("t2_bits", fbits[0], 'h34A);
    chk("t2_len", flen[0], 40);
    chk("t2_len_par", flen[1], 44);

    // Three bytes back to back
    b0 = rdc[0];
    push_byte(8'h01); push_byte(8'h80); push_byte(8'hFF);
    wait_idle("t3", 1'b1);
    chk("t3_rd_pulses", rdc[0] - b0, 3);
    chk("t3_gap", gap[0], 3);
    chk("t3_gap_par", gap[1], 3);
    chk("t3_last_bits", fbits[0], 'h3FE);
    chk("t3_empty", fcount(0), 0);

    // Reset in the middle of data bit 0
    push_byte(8'h3C);
    tick(10);
    chk("t1_pre_busy", busy_w[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_txd", txd_w[0], 1);
    chk("t1_rd", rd_w[0], 0);
    chk("t1_busy", busy_w[0], 0);
    chk("t1_busy_par", busy_w[1], 0);
    tick(3);
    rst_n = 1'b1;
    b0 = rdc[0];
    tick(60);
    chk("t1_no_frame", rdc[0] - b0, 0);
    chk("t1_idle_txd", txd_w[1], 1);

    // Enable gating
    en = 1'b0;
    b0 = rdc[0];
    push_byte(8'h11); push_byte(8'h22);
    tick(30);
    chk("t4_no_rd", rdc[0] - b0, 0);
    en = 1'b1;
    tick(10);
    en = 1'b0;
    wait_idle("t4a", 1'b0);
    tick(20);
    chk("t4_withheld", fcount(0), 1);
    chk("t4_withheld_par", fcount(1), 1);
    chk("t4_one_rd", rdc[0] - b0, 1);
    en = 1'b1;
    wait_idle("t4b", 1'b1);
    chk("t4_two_rd", rdc[0] - b0, 2);
    chk("t4_bits", fbits[0], 'h244);

    // Parity frames
    push_byte(8'h07);
    wait_idle("t5a", 1'b1);
    chk("t5_par1_bits", fbits[1], 'h60E);
    chk("t5_len", flen[1], 44);
    push_byte(8'h03);
    wait_idle("t5b", 1'b1);
    chk("t5_par0_bits", fbits[1], 'h406);
    chk("t5_nopar_bits", fbits[0], 'h206);

    // Random traffic across pointer wrap
    b0 = rdc[0]; b1 = rdc[1];
    for (int i = 0; i < 20; i++) begin
      push_byte(8'($urandom));
      tick($urandom_range(0, 30));
    end
    wait_idle("t6", 1'b1);
    chk("t6_rd", rdc[0] - b0, 20);
    chk("t6_rd_par", rdc[1] - b1, 20);
    chk("t6_empty", fcount(1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
